csi_rx_byte_align: RTL and testbench

Per-lane HS byte aligner and lock controller for the CSI-2 receiver. It sits directly behind each lane PHY and takes the raw, bit-misaligned 8-bit deserializer words plus their valid strobe. It hunts for the HS sync byte, locks the bit offset, and forwards byte-aligned payload to the lane merger and packet layer. It also sequences return-to-search at end of packet, on HS exit, or on runaway packets.

---
 rtl/csi_rx_pkg.sv | 12 +
 rtl/csi_rx_sync_detect.sv | 23 ++
 rtl/csi_rx_byte_align.sv | 117 +++++++++++
 tb/tb_csi_rx_byte_align.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/csi_rx_pkg.sv
// CSI-2 receiver shared types.
// Sync byte value and lane lock states.
package csi_rx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } csi_rx_state_e;

endpackage

// File: rtl/csi_rx_sync_detect.sv
// HS sync byte matcher over a 16-bit window.
// Lowest matching bit offset wins.
module csi_rx_sync_detect
  import csi_rx_pkg::*;
(
  input  logic [15:0] win,
  output logic        hit,
  output logic [2:0]  k
);

  // Scan high to low so the lowest offset is written last.
  always_comb begin
    hit = 1'b0;
    k   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (win[i +: 8] == SYNC_BYTE) begin
        hit = 1'b1;
        k   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/csi_rx_byte_align.sv
// Per-lane HS byte aligner and lock controller.
// Hunts the sync byte, locks the offset, forwards bytes.
module csi_rx_byte_align
  import csi_rx_pkg::*;
#(
  parameter int unsigned MAX_PKT_BYTES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hs_en,
  input  logic       din_valid,
  input  logic [7:0] din,
  input  logic       pkt_done,
  output logic       dout_valid,
  output logic [7:0] dout,
  output logic       aligned,
  output logic [2:0] offset,
  output logic       timeout
);

  localparam logic [16:0] MAX_CNT = 17'(MAX_PKT_BYTES);

  csi_rx_state_e state_q, state_d;
  logic [7:0]  prev_q;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]  offset_q, offset_d;
  logic [7:0]  dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        timeout_q, timeout_d;
  logic        aligned_q;

  logic [15:0] win;
  logic        hit;
  logic [2:0]  hit_k;
  logic [7:0]  lane_byte;
  logic        last_byte;

  assign win       = {din, prev_q};
  assign lane_byte = 8'(win >> offset_q);
  assign last_byte = ({1'b0, byte_cnt_q} + 17'd1) == MAX_CNT;

  csi_rx_sync_detect u_sync (
    .win (win),
    .hit (hit),
    .k   (hit_k)
  );

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    offset_d     = offset_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    timeout_d    = 1'b0;
    if (!hs_en) begin
      state_d = SEARCH;
    end else if (pkt_done && state_q == LOCKED) begin
      state_d = SEARCH;
    end else if (din_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (hit) begin
            state_d    = LOCKED;
            offset_d   = hit_k;
            byte_cnt_d = 16'd0;
          end
        end
        LOCKED: begin
          dout_valid_d = 1'b1;
          dout_d       = lane_byte;
          if (!(&byte_cnt_q)) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
          end
          // Runaway packet: last byte goes out with the pulse.
          if (last_byte) begin
            timeout_d = 1'b1;
            state_d   = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      prev_q       <= 8'd0;
      byte_cnt_q   <= 16'd0;
      offset_q     <= 3'd0;
      dout_q       <= 8'd0;
      dout_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      aligned_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      offset_q     <= offset_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      timeout_q    <= timeout_d;
      aligned_q    <= (state_d == LOCKED);
      if (!hs_en) begin
        prev_q <= 8'd0;
      end else if (din_valid) begin
        prev_q <= din;
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign aligned    = aligned_q;
  assign offset     = offset_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_csi_rx_byte_align.sv
// Directed bench for csi_rx_byte_align.
// Hand-computed vectors, MAX_PKT_BYTES=4.
module tb_csi_rx_byte_align;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hs_en;
  logic       din_valid;
  logic [7:0] din;
  logic       pkt_done;
  logic       dout_valid;
  logic [7:0] dout;
  logic       aligned;
  logic [2:0] offset;
  logic       timeout;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csi_rx_byte_align #(
    .MAX_PKT_BYTES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hs_en      (hs_en),
    .din_valid  (din_valid),
    .din        (din),
    .pkt_done   (pkt_done),
    .dout_valid (dout_valid),
    .dout       (dout),
    .aligned    (aligned),
    .offset     (offset),
    .timeout    (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic pd);
    @(negedge clk);
    din       = d;
    din_valid = 1'b1;
    pkt_done  = pd;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    pkt_done  = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic hs_off();
    @(negedge clk);
    hs_en = 1'b0;
    @(posedge clk);
    #1;
    hs_en = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    rst_n     = 1'b0;
    hs_en     = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    pkt_done  = 1'b0;
    idle();
    idle();
    chk("rst_dv", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_al", aligned, 0);
    chk("rst_off", offset, 0);
    chk("rst_to", timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hs_en = 1'b1;

    // offset 3 lock
    beat(8'h00, 0);
    chk("o3_dv0", dout_valid, 0);
    beat(8'hC0, 0);
    chk("o3_dv1", dout_valid, 0);
    chk("o3_al1", aligned, 0);
    beat(8'h2D, 0);
    chk("o3_dv2", dout_valid, 0);
    chk("o3_al2", aligned, 1);
    chk("o3_off", offset, 3);
    beat(8'h05, 0);
    chk("o3_dv3", dout_valid, 1);
    chk("o3_dout", dout, 8'hA5);
    idle();
    chk("o3_once", dout_valid, 0);

    // offset sweep
    for (int k = 0; k < 8; k++) begin
      hs_off();
      v = 32'h0022_11B8 << k;
      beat(v[7:0], 0);
      chk($sformatf("sw%0d_al0", k), aligned, 0);
      beat(v[15:8], 0);
      chk($sformatf("sw%0d_al", k), aligned, 1);
      chk($sformatf("sw%0d_off", k), offset, k);
      chk($sformatf("sw%0d_dv0", k), dout_valid, 0);
      beat(v[23:16], 0);
      chk($sformatf("sw%0d_dv1", k), dout_valid, 1);
      chk($sformatf("sw%0d_b1", k), dout, 8'h11);
      beat(v[31:24], 0);
      chk($sformatf("sw%0d_dv2", k), dout_valid, 1);
      chk($sformatf("sw%0d_b2", k), dout, 8'h22);
    end

    // pkt_done with a beat
    beat(8'h33, 1);
    chk("pd_dv", dout_valid, 0);
    chk("pd_al", aligned, 0);
    beat(8'h00, 0);
    chk("pd_dv1", dout_valid, 0);
    chk("pd_al1", aligned, 0);
    beat(8'h00, 0);
    chk("pd_dv2", dout_valid, 0);

    // HS exit mid-packet
    hs_off();
    beat(8'h00, 0);
    beat(8'hC0, 0);
    beat(8'h2D, 0);
    chk("hs_lock", aligned, 1);
    hs_off();
    chk("hs_al", aligned, 0);
    beat(8'h05, 0);
    chk("hs_al1", aligned, 0);
    chk("hs_dv1", dout_valid, 0);
    beat(8'h2D, 0);
    chk("hs_al2", aligned, 0);
    chk("hs_dv2", dout_valid, 0);

    // timeout after 4 bytes
    hs_off();
    beat(8'hB8, 0);
    beat(8'h01, 0);
    chk("to_lock", aligned, 1);
    chk("to_off", offset, 0);
    for (int i = 0; i < 3; i++) begin
      beat(8'(i + 2), 0);
      chk($sformatf("to_dv%0d", i), dout_valid, 1);
      chk($sformatf("to_d%0d", i), dout, i + 1);
      chk($sformatf("to_p%0d", i), timeout, 0);
    end
    beat(8'h05, 0);
    chk("to_dv3", dout_valid, 1);
    chk("to_d3", dout, 8'h04);
    chk("to_pulse", timeout, 1);
    chk("to_al", aligned, 0);
    beat(8'h06, 0);
    chk("to_dv4", dout_valid, 0);
    chk("to_p4", timeout, 0);
    chk("to_al4", aligned, 0);
    beat(8'h07, 0);
    chk("to_dv5", dout_valid, 0);

    // reset while locked
    hs_off();
    beat(8'h00, 0);
    beat(8'hC0, 0);
    beat(8'h2D, 0);
    chk("rl_lock", aligned, 1);
    @(negedge clk);
    rst_n     = 1'b0;
    din       = 8'h05;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rl_dv", dout_valid, 0);
    chk("rl_dout", dout, 0);
    chk("rl_al", aligned, 0);
    chk("rl_off", offset, 0);
    chk("rl_to", timeout, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    din_valid = 1'b0;
    idle();
    chk("rl_dv2", dout_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
